// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Shadow contents swap only at frame boundaries; all outputs are registered.
module seg_scan_ctrl #(
  parameter int NUM_DIG   = 8,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd_valid,
  input  logic [31:0]        upd_data,
  input  logic [7:0]         upd_mask,
  output logic               upd_ready,
  output logic [3:0]         nibble,
  output logic [NUM_DIG-1:0] dig_sel,
  output logic               frame_done
);

  localparam int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIG - 1);
  localparam logic [CNT_W-1:0] DRIVE_END = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);

  typedef enum logic {BLANK, DRIVE} state_t;
  typedef logic [NUM_DIG-1:0][3:0] digits_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  digits_t            shadow_data, shadow_data_n;
  digits_t            pend_data, pend_data_n;
  logic [NUM_DIG-1:0] shadow_mask, shadow_mask_n;
  logic [NUM_DIG-1:0] pend_mask, pend_mask_n;
  logic               pend, pend_n;
  logic               boundary;
  logic               xfer;
  logic [NUM_DIG-1:0] one_hot;
  logic [NUM_DIG-1:0] dig_sel_n;
  logic [3:0]         nibble_n;

  assign xfer = upd_valid & upd_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_n       = state;
    idx_n         = idx;
    cnt_n         = cnt + CNT_W'(1);
    boundary      = 1'b0;
    shadow_data_n = shadow_data;
    shadow_mask_n = shadow_mask;
    pend_data_n   = pend_data;
    pend_mask_n   = pend_mask;
    pend_n        = pend;

    case (state)
      BLANK: begin
        if (cnt == BLANK_END) begin
          cnt_n   = '0;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == DRIVE_END) begin
          cnt_n    = '0;
          state_n  = BLANK;
          boundary = (idx == LAST_IDX);
          idx_n    = boundary ? '0 : idx + IDX_W'(1);
        end
      end
      default: state_n = BLANK;
    endcase

    // Only an update captured before the boundary cycle is applied there.
    if (boundary && pend) begin
      shadow_data_n = pend_data;
      shadow_mask_n = pend_mask;
      pend_n        = 1'b0;
    end
    if (xfer) begin
      pend_data_n = upd_data[4*NUM_DIG-1:0];
      pend_mask_n = upd_mask[NUM_DIG-1:0];
      pend_n      = 1'b1;
    end

    // Outputs are derived from next-state values so the registers line up with state.
    one_hot   = NUM_DIG'(1) << idx_n;
    nibble_n  = shadow_data_n[idx_n];
    dig_sel_n = (state_n == DRIVE && shadow_mask_n[idx_n]) ? ~one_hot : '1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BLANK;
      idx         <= '0;
      cnt         <= '0;
      // NOTE: shadow and pending storage is reset too, so a reset display shows a blank, known frame.
      shadow_data <= '0;
      shadow_mask <= '0;
      pend_data   <= '0;
      pend_mask   <= '0;
      pend        <= 1'b0;
      nibble      <= '0;
      dig_sel     <= '1;
      upd_ready   <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all of them update together.
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      shadow_data <= shadow_data_n;
      shadow_mask <= shadow_mask_n;
      pend_data   <= pend_data_n;
      pend_mask   <= pend_mask_n;
      pend        <= pend_n;
      nibble      <= nibble_n;
      dig_sel     <= dig_sel_n;
      upd_ready   <= ~pend_n;
      frame_done  <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame-position reference model,
// table-driven update vectors, hand-written corner sequences and random traffic.
module tb_seg_scan_ctrl;

  localparam int NUM_DIG   = 4;
  localparam int DIV       = 4;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = BLANK_CYC + DIV;
  localparam int FRAME     = NUM_DIG * SLOT;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               upd_valid = 1'b0;
  logic [31:0]        upd_data = '0;
  logic [7:0]         upd_mask = '0;
  logic               upd_ready;
  logic [3:0]         nibble;
  logic [NUM_DIG-1:0] dig_sel;
  logic               frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIG(NUM_DIG), .DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_data(upd_data),
    .upd_mask(upd_mask), .upd_ready(upd_ready), .nibble(nibble),
    .dig_sel(dig_sel), .frame_done(frame_done)
  );

  // Reference model: displayed contents plus a single pending slot; position in
  // the frame comes purely from the number of clock edges since reset release.
  logic [3:0]         m_dig  [NUM_DIG];
  logic [3:0]         m_pdig [NUM_DIG];
  logic [NUM_DIG-1:0] m_mask, m_pmask;
  bit                 m_pend;
  int                 m_k;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  mask;
    logic [15:0] exp_nib;
    logic [3:0]  exp_lit;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_DIG; i++) begin
      m_dig[i]  = '0;
      m_pdig[i] = '0;
    end
    m_mask  = '0;
    m_pmask = '0;
    m_pend  = 1'b0;
    m_k     = 0;
  endtask

  task automatic check_outputs();
    int p, d, q;
    logic [3:0] one, exp_sel;
    p   = m_k % FRAME;
    d   = p / SLOT;
    q   = p % SLOT;
    one = 4'b0001;
    exp_sel = (q >= BLANK_CYC && m_mask[d]) ? ~(one << d) : 4'hF;
    check("dig_sel", dig_sel, exp_sel);
    check("nibble", nibble, m_dig[d]);
    check("upd_ready", upd_ready, !m_pend);
    check("frame_done", frame_done, (p == 0 && m_k > 0));
  endtask

  task automatic step();
    bit xfer, bnd;
    @(posedge clk);
    xfer = upd_valid && !m_pend;
    bnd  = (m_k % FRAME) == FRAME - 1;
    if (bnd && m_pend) begin
      m_dig  = m_pdig;
      m_mask = m_pmask;
      m_pend = 1'b0;
    end
    if (xfer) begin
      for (int i = 0; i < NUM_DIG; i++) m_pdig[i] = upd_data[4*i +: 4];
      m_pmask = upd_mask[NUM_DIG-1:0];
      m_pend  = 1'b1;
    end
    m_k++;
    #1 check_outputs();
  endtask

  task automatic send(input logic [31:0] data, input logic [7:0] mask);
    upd_valid = 1'b1;
    upd_data  = data;
    upd_mask  = mask;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int budget = 0;
    while (!upd_ready && budget < 3 * FRAME) begin
      step();
      budget++;
    end
    if (!upd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ready: upd_ready stuck at 0 after %0d cycles", budget);
    end
  endtask

  task automatic wait_apply();
    int budget = 0;
    while (m_pend && budget < 3 * FRAME) begin
      step();
      budget++;
    end
  endtask

  task automatic run_to_boundary();
    while (m_k % FRAME != FRAME - 1) step();
  endtask

  // Observe one whole frame starting at frame position 0.
  task automatic scan_frame(output logic [15:0] seen, output logic [3:0] lit, output int fd);
    int p;
    seen = '0;
    lit  = '0;
    fd   = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      p = m_k % FRAME;
      if (p % SLOT >= BLANK_CYC) seen[4*(p/SLOT) +: 4] = nibble;
      lit |= ~dig_sel;
      if (frame_done) fd++;
    end
  endtask

  vec_t        vecs [4];
  logic [15:0] seen;
  logic [3:0]  lit;
  int          fd;

  initial begin
    vecs[0] = '{data: 32'h0000_4321, mask: 8'h0F, exp_nib: 16'h4321, exp_lit: 4'hF};
    vecs[1] = '{data: 32'h0000_ABCD, mask: 8'h05, exp_nib: 16'hABCD, exp_lit: 4'h5};
    vecs[2] = '{data: 32'h1234_5678, mask: 8'hFA, exp_nib: 16'h5678, exp_lit: 4'hA};
    vecs[3] = '{data: 32'hFFFF_9E0F, mask: 8'hF0, exp_nib: 16'h9E0F, exp_lit: 4'h0};

    // Reset values, then a dark first frame.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    rst = 1'b1;
    scan_frame(seen, lit, fd);
    check("first_frame_dark", lit, 4'h0);

    // Table-driven updates: each one must be shown whole on the frame after it lands.
    for (int v = 0; v < 4; v++) begin
      wait_ready();
      send(vecs[v].data, vecs[v].mask);
      check("ready_low_after_xfer", upd_ready, 1'b0);
      wait_apply();
      scan_frame(seen, lit, fd);
      check("vec_nibbles", seen, vecs[v].exp_nib);
      check("vec_lit", lit, vecs[v].exp_lit);
      check("vec_frame_done_count", fd, 1);
    end

    // Transfer in the boundary cycle: captured, but applied one frame later.
    wait_ready();
    run_to_boundary();
    send(32'h0000_2468, 8'h0F);
    check("collide_old_nib", nibble, 4'hF);
    check("collide_ready", upd_ready, 1'b0);
    repeat (FRAME - 1) step();
    check("collide_still_pending", upd_ready, 1'b0);
    step();
    check("collide_new_nib", nibble, 4'h8);
    check("collide_ready_back", upd_ready, 1'b1);

    // Back-pressure: valid held with changing data while not ready.
    wait_ready();
    send(32'h0000_1111, 8'h0F);
    upd_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME && m_pend; i++) begin
      upd_data = $urandom;
      upd_mask = 8'($urandom);
      step();
    end
    upd_valid = 1'b0;
    scan_frame(seen, lit, fd);
    check("bp_nibbles", seen, 16'h1111);
    check("bp_lit", lit, 4'hF);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      upd_valid = ($urandom_range(0, 3) == 0);
      upd_data  = $urandom;
      upd_mask  = 8'($urandom);
      step();
    end
    upd_valid = 1'b0;

    // Mid-frame reset during DRIVE of digit 2 with an update pending.
    wait_ready();
    send(32'h0000_5A5A, 8'h0F);
    wait_apply();
    send(32'h0000_0F0F, 8'h0F);
    while (m_k % FRAME != 2 * SLOT + BLANK_CYC + 1) step();
    check("pre_reset_sel", dig_sel, 4'b1011);
    #2 rst = 1'b0;
    #1;
    check("async_reset_sel", dig_sel, 4'hF);
    check("async_reset_nibble", nibble, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    scan_frame(seen, lit, fd);
    check("post_reset_dark", lit, 4'h0);
    scan_frame(seen, lit, fd);
    check("pending_discarded", lit, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
- Holds a shadow copy of up to 8 hex digits and presents one 4-bit nibble at a time to the registered hex-to-segment decoder, which has 1 clk latency.
- Drives the active-low digit selects, inserting a blanking gap between digits to prevent ghosting.
- Accepts new display contents through a valid/ready handshake and applies them only at a frame boundary, so a frame never mixes old and new digits.

Parameters:
- NUM_DIG, 8: number of digits scanned. Legal range 1..8.
- DIV, 50000: clk cycles each digit is driven (DRIVE dwell). Must be >= 1.
- BLANK_CYC, 16: clk cycles of blanking before each digit. Must be >= 2 so the registered decoder settles.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset. Logic resets while rst=0.
- upd_valid  in  1  new display contents offered.
- upd_data  in  32  digit i = upd_data[4i+3:4i]. Bits for i >= NUM_DIG are ignored.
- upd_mask  in  8  digit i is lit only if upd_mask[i]=1. Bits for i >= NUM_DIG are ignored.
- upd_ready  out  1  controller can accept an update.
- nibble  out  4  value for the current digit, to the decoder data input.
- dig_sel  out  NUM_DIG  active-low digit enables. At most one bit is low at any time.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (rst=0, async):
  - state=BLANK, idx=0, cnt=0.
  - shadow data=0, shadow mask=0, pending flag=0, pending regs=0.
  - Outputs: nibble=0, dig_sel=all 1s, upd_ready=1, frame_done=0.
  - Reset asserted mid-frame aborts the scan immediately and discards any pending update.
- Registered outputs: nibble, dig_sel, upd_ready and frame_done are all registered.
- State BLANK:
  - dig_sel=all 1s; nibble=shadow digit[idx].
  - cnt counts 0..BLANK_CYC-1. When cnt=BLANK_CYC-1: cnt<=0, state<=DRIVE.
- State DRIVE:
  - dig_sel[idx]=0 if shadow_mask[idx]=1, otherwise all 1s. nibble holds shadow digit[idx].
  - cnt counts 0..DIV-1. When cnt=DIV-1: cnt<=0, state<=BLANK, idx<=idx+1.
  - Wrap: if idx=NUM_DIG-1, idx<=0 instead.
- Frame boundary = the DRIVE exit cycle where idx=NUM_DIG-1.
  - frame_done=1 for exactly the following cycle.
  - If the pending flag was already set before that cycle, shadow data/mask <= pending regs, the pending flag clears, and the new frame starts at idx 0 with the new contents.
- Frame length is NUM_DIG*(BLANK_CYC+DIV) cycles.
- Update handshake:
  - A transfer occurs on a clk edge with upd_valid=1 and upd_ready=1: pending regs <= upd_data/upd_mask, pending flag <= 1, upd_ready <= 0.
  - upd_ready returns to 1 on the cycle after the pending contents are applied.
  - Only one outstanding update is held. upd_valid while upd_ready=0 is ignored and is not a transfer.
  - Transfer in the same cycle as a frame boundary: the capture succeeds but is not applied at that boundary. It is applied at the next boundary.
- Timing relative to the decoder: nibble changes only on BLANK entry, so the decoder output is stable >= 1 cycle before any dig_sel bit goes low.
- Widths: idx is clog2(NUM_DIG) bits, minimum 1. cnt is wide enough for max(DIV, BLANK_CYC)-1.
- NUM_DIG=1: idx stays 0, and every DRIVE exit is a frame boundary.

Test Plan (all tests use NUM_DIG=4, DIV=4, BLANK_CYC=2, so a frame is 24 cycles):
- Reset values: hold rst=0 for 3 cycles, then release. Required: dig_sel=4'b1111, nibble=0, upd_ready=1, frame_done=0. dig_sel stays 4'b1111 for the whole first frame because the mask is 0.
- Update and scan order: transfer upd_data=32'h0000_4321, upd_mask=8'h0F.
  - Required: upd_ready=0 until the first boundary.
  - From the next frame on, nibble sequence is 1,2,3,4.
  - dig_sel sequence per 6 cycles is 1111,1111,1110×4, then 1111,1111,1101×4, and so on for the remaining digits.
  - frame_done pulses every 24 cycles.
- Masking: upd_mask=8'h05, data 32'h0000_ABCD. Required: dig_sel[1] and dig_sel[3] never go low; nibble still cycles D,C,B,A.
- Boundary collision: transfer in the exact boundary cycle. Required: the current frame still shows the old data, the new data appears one frame later, and upd_ready returns 1 after that application.
- Back-pressure: hold upd_valid=1 with changing data while upd_ready=0. Required: only the first captured value is ever displayed.
- Mid-frame reset: assert rst=0 during DRIVE of idx 2 with an update pending. Required: dig_sel=1111 immediately (asynchronously). After release, mask=0 and nothing is lit until a new update.
